cordic_gain_comp: RTL

- Downstream of the last micro-rotation stage of the CORDIC pipeline; consumes its X/Y/valid outputs.
- Removes the CORDIC gain by multiplying X and Y by K = 0.6072529.
  - The multiply uses a fixed shift-add term set, not a hardware multiplier.
  - The result is rounded.
- Applies the optional 180° quadrant correction (negation) that was tagged on the sample at pipeline entry.
- Fully pipelined: accepts one sample per clock, no backpressure.

---
 rtl/cordic_pkg.sv | 15 +
 rtl/cordic_kmul.sv | 107 ++++++++++
 rtl/cordic_gain_comp.sv | 53 +++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC gain-compensation stage: default widths and the K shift-add term set.
package cordic_pkg;

    localparam int unsigned ODAT_WIDTH_DEF = 16;
    localparam int unsigned GUARD_BITS_DEF = 4;

    // K ~= 0.6072540 as a signed sum of arithmetic right shifts of the extended input
    localparam int unsigned NUM_TERMS = 7;
    localparam int unsigned K_SHIFT [NUM_TERMS] = '{1, 3, 6, 9, 13, 15, 16};
    // Bit i set means term i is subtracted
    localparam logic [NUM_TERMS-1:0] K_NEG = 7'b111_1100;
    // Terms [0, P1_TERMS) are summed into P1, the rest into P2
    localparam int unsigned P1_TERMS = 3;

endpackage

// File: rtl/cordic_kmul.sv
// Single-channel gain compensation: 3-stage shift-add multiply by K, round half up, conditional negate.
module cordic_kmul
    import cordic_pkg::*;
#(
    parameter int unsigned ODatWidth = ODAT_WIDTH_DEF,
    parameter int unsigned GuardBits = GUARD_BITS_DEF
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_val,
    input  logic                        i_flip,
    input  logic signed [ODatWidth-1:0] i_dat,
    output logic                        o_val,
    output logic signed [ODatWidth-1:0] o_dat
);

    localparam int unsigned ExtW = ODatWidth + GuardBits;
    localparam int unsigned SumW = ExtW + 1;
    localparam logic signed [SumW-1:0] RoundInc = SumW'(1 << (GuardBits - 1));

    logic signed [SumW-1:0] w_ext;
    logic signed [SumW-1:0] w_term [NUM_TERMS];
    logic signed [SumW-1:0] w_p1;
    logic signed [SumW-1:0] w_p2;
    logic signed [SumW-1:0] w_sh;

    logic                   r_val1;
    logic                   r_flip1;
    logic signed [SumW-1:0] r_p1;
    logic signed [SumW-1:0] r_p2;
    logic                   r_val2;
    logic                   r_flip2;
    logic signed [SumW-1:0] r_s;

    // Sign-extend by one bit of headroom and append the guard bits
    assign w_ext = {i_dat[ODatWidth-1], i_dat, {GuardBits{1'b0}}};

    // Individual K terms; arithmetic shifts truncate toward minus infinity
    always_comb begin
        for (int unsigned i = 0; i < NUM_TERMS; i++) begin
            w_term[i] = w_ext >>> K_SHIFT[i];
        end
    end

    // P1 collects the leading terms, P2 the magnitude of the trailing negative terms
    always_comb begin
        w_p1 = '0;
        w_p2 = '0;
        for (int unsigned i = 0; i < NUM_TERMS; i++) begin
            if (i < P1_TERMS) begin
                if (K_NEG[i]) w_p1 = w_p1 - w_term[i];
                else          w_p1 = w_p1 + w_term[i];
            end else begin
                if (K_NEG[i]) w_p2 = w_p2 + w_term[i];
                else          w_p2 = w_p2 - w_term[i];
            end
        end
    end

    // Stage 1: partial sums, flip tag carried alongside
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_val1  <= 1'b0;
            r_flip1 <= 1'b0;
            r_p1    <= '0;
            r_p2    <= '0;
        end else begin
            r_val1 <= i_val;
            if (i_val) begin
                r_flip1 <= i_flip;
                r_p1    <= w_p1;
                r_p2    <= w_p2;
            end
        end
    end

    // Stage 2: final sum plus half an output LSB for round-half-up
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_val2  <= 1'b0;
            r_flip2 <= 1'b0;
            r_s     <= '0;
        end else begin
            r_val2 <= r_val1;
            if (r_val1) begin
                r_flip2 <= r_flip1;
                r_s     <= r_p1 - r_p2 + RoundInc;
            end
        end
    end

    assign w_sh = r_s >>> GuardBits;

    // Stage 3: drop guard bits, negate on flip at full width, truncate only here
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_val <= 1'b0;
            o_dat <= '0;
        end else begin
            o_val <= r_val2;
            if (r_val2) begin
                o_dat <= ODatWidth'(r_flip2 ? -w_sh : w_sh);
            end
        end
    end

endmodule

// File: rtl/cordic_gain_comp.sv
// CORDIC gain removal for the X/Y pair; two lockstep channels, output valid taken from X.
module cordic_gain_comp
    import cordic_pkg::*;
#(
    parameter int unsigned ODatWidth = ODAT_WIDTH_DEF,
    parameter int unsigned GuardBits = GUARD_BITS_DEF
) (
    input  logic                        Clk_i,
    input  logic                        Rst_i,
    input  logic signed [ODatWidth-1:0] X_i,
    input  logic signed [ODatWidth-1:0] Y_i,
    input  logic                        Flip_i,
    input  logic                        Val_i,
    output logic signed [ODatWidth-1:0] X_o,
    output logic signed [ODatWidth-1:0] Y_o,
    output logic                        Val_o
);

    logic w_x_val;
    logic w_y_val;

    cordic_kmul #(
        .ODatWidth (ODatWidth),
        .GuardBits (GuardBits)
    ) u_kmul_x (
        .i_clk  (Clk_i),
        .i_rst  (Rst_i),
        .i_val  (Val_i),
        .i_flip (Flip_i),
        .i_dat  (X_i),
        .o_val  (w_x_val),
        .o_dat  (X_o)
    );

    cordic_kmul #(
        .ODatWidth (ODatWidth),
        .GuardBits (GuardBits)
    ) u_kmul_y (
        .i_clk  (Clk_i),
        .i_rst  (Rst_i),
        .i_val  (Val_i),
        .i_flip (Flip_i),
        .i_dat  (Y_i),
        .o_val  (w_y_val),
        .o_dat  (Y_o)
    );

    assign Val_o = w_x_val;

    // Both channels see identical valid/reset, so their valid pipelines never diverge
    a_val_lockstep : assert property (@(posedge Clk_i) w_x_val == w_y_val);

endmodule
